// File: rtl/imm_ext_pkg.sv
// ---------------------------------------------------------------------------
// imm_ext_pkg
// Shared types for the immediate-extension stage and the blocks that reuse
// its extension core (e.g. jump-target logic).
//   imm_mode_e : extension mode carried on in_mode / i_mode
//   state_e    : occupancy of the output/skid register pair
// ---------------------------------------------------------------------------
package imm_ext_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        IMM_SIGN   = 2'b00,
        IMM_ZERO   = 2'b01,
        IMM_UPPER  = 2'b10,
        IMM_BRANCH = 2'b11
    } imm_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,   // OR empty, SR empty
        ST_ONE   = 2'b01,   // OR full,  SR empty
        ST_TWO   = 2'b10    // OR full,  SR full
    } state_e;

endpackage

// File: rtl/imm_extend_core.sv
// ---------------------------------------------------------------------------
// imm_extend_core
// Purely combinational immediate extension f(imm, mode) -> {ovf, data}.
//   i_imm  [IN_W]  raw immediate
//   i_mode         SIGN / ZERO / UPPER / BRANCH
//   o_data [OUT_W] extended value
//   o_ovf          BRANCH only: significant bits lost by the left shift
// UPPER mode is meaningful only when OUT_W >= 2*IN_W.
// ---------------------------------------------------------------------------
module imm_extend_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHAMT = 2
) (
    input  logic [IN_W-1:0]  i_imm,
    input  imm_mode_e        i_mode,
    output logic [OUT_W-1:0] o_data,
    output logic             o_ovf
);

    localparam int EXT_W = OUT_W - IN_W;

    logic             w_sign;
    logic [OUT_W-1:0] w_sext;

    assign w_sign = i_imm[IN_W-1];
    assign w_sext = {{EXT_W{w_sign}}, i_imm};

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case can leave it unassigned and infer a latch.
        o_data = w_sext;
        o_ovf  = 1'b0;
        unique case (i_mode)
            IMM_SIGN:   o_data = w_sext;
            IMM_ZERO:   o_data = {{EXT_W{1'b0}}, i_imm};
            IMM_UPPER:  o_data = {i_imm, {EXT_W{1'b0}}};
            IMM_BRANCH: begin
                o_data = w_sext << SHAMT;
                // The SHAMT bits shifted out plus the new MSB must all still
                // equal the original sign, otherwise the offset overflowed.
                for (int i = OUT_W - 1 - SHAMT; i < OUT_W; i++) begin
                    if (w_sext[i] != w_sign) begin
                        o_ovf = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
// Registered immediate-extension stage with a valid/ready handshake and a
// two-entry (output + skid) buffer. in_ready comes from registered state only.
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake
//   in_imm [IN_W]         raw immediate, sampled only on an in transfer
//   in_mode [2]           SIGN / ZERO / UPPER / BRANCH
//   out_valid / out_ready downstream handshake
//   out_data [OUT_W]      extended value
//   out_ovf               BRANCH overflow flag
// ---------------------------------------------------------------------------
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHAMT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_ovf
);

    // Stored result is {ovf, data}; raw immediate and mode are never kept.
    logic [OUT_W:0]   w_result;
    logic [OUT_W-1:0] w_ext_data;
    logic             w_ext_ovf;

    state_e           r_state;
    state_e           w_next_state;
    logic             r_rdy_en;      // 0 during reset, 1 from the first edge after
    logic [OUT_W:0]   r_or;          // output register
    logic [OUT_W:0]   r_sr;          // skid register

    logic             w_push;
    logic             w_pop;
    logic             w_or_load_new;
    logic             w_or_load_sr;
    logic             w_sr_load;

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHAMT (SHAMT)
    ) u_core (
        .i_imm  (in_imm),
        .i_mode (imm_mode_e'(in_mode)),
        .o_data (w_ext_data),
        .o_ovf  (w_ext_ovf)
    );

    assign w_result = {w_ext_ovf, w_ext_data};
    assign w_push   = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_EMPTY;
            r_rdy_en <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_state  <= w_next_state;
            r_rdy_en <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_EMPTY: if (w_push) w_next_state = ST_ONE;
            ST_ONE: begin
                if (w_push && !w_pop)      w_next_state = ST_TWO;
                else if (!w_push && w_pop) w_next_state = ST_EMPTY;
            end
            ST_TWO:   if (w_pop) w_next_state = ST_ONE;
            default:  w_next_state = ST_EMPTY;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        in_ready  = r_rdy_en && (r_state != ST_TWO);
        out_valid = (r_state != ST_EMPTY);
    end

    // Register load enables. A new result goes straight to OR when OR is free
    // or is being drained this cycle; it parks in SR only when OR is held.
    assign w_or_load_new = w_push && ((r_state == ST_EMPTY) ||
                                      (r_state == ST_ONE && w_pop));
    assign w_or_load_sr  = (r_state == ST_TWO) && w_pop;
    assign w_sr_load     = (r_state == ST_ONE) && w_push && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: data registers are cleared on reset here because the
            // outputs and the skid slot must read zero, not just be invalid.
            r_or <= '0;
            r_sr <= '0;
        end else begin
            if (w_or_load_new)     r_or <= w_result;
            else if (w_or_load_sr) r_or <= r_sr;
            if (w_sr_load)         r_sr <= w_result;
        end
    end

    assign out_data = r_or[OUT_W-1:0];
    assign out_ovf  = r_or[OUT_W];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_extend_pipe
// Self-checking bench for imm_extend_pipe. Three instances:
//   a : defaults (16 -> 32, SHAMT 2)
//   b : 16 -> 17, SHAMT 2 (BRANCH overflow)
//   c : 8 -> 24, SHAMT 2 (random handshake against a scoreboard)
// ---------------------------------------------------------------------------
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    logic clk;
    logic reset;

    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_ovf_a;
    logic [15:0] in_imm_a;
    logic [1:0]  in_mode_a;
    logic [31:0] out_data_a;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_ovf_b;
    logic [15:0] in_imm_b;
    logic [1:0]  in_mode_b;
    logic [16:0] out_data_b;

    logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_ovf_c;
    logic [7:0]  in_imm_c;
    logic [1:0]  in_mode_c;
    logic [23:0] out_data_c;

    int n_vec = 0;
    int n_err = 0;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHAMT(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_imm(in_imm_a), .in_mode(in_mode_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(out_data_a), .out_ovf(out_ovf_a)
    );

    imm_extend_pipe #(.IN_W(16), .OUT_W(17), .SHAMT(2)) u_dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_imm(in_imm_b), .in_mode(in_mode_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_ovf(out_ovf_b)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(24), .SHAMT(2)) u_dut_c (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_imm(in_imm_c), .in_mode(in_mode_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c),
        .out_data(out_data_c), .out_ovf(out_ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference for the 8 -> 24, SHAMT 2 instance, written arithmetically:
    // BRANCH overflows iff imm*4 does not fit a 24-bit signed value.
    function automatic logic [24:0] model8(input logic [7:0] imm, input logic [1:0] mode);
        int s;
        int p;
        logic [24:0] r;
        s = imm[7] ? int'(imm) - 256 : int'(imm);
        p = s * 4;
        case (mode)
            2'b00:   r = {1'b0, s[23:0]};
            2'b01:   r = {1'b0, 16'h0000, imm};
            2'b10:   r = {1'b0, imm, 16'h0000};
            default: r = {((p < -8388608) || (p > 8388607)), p[23:0]};
        endcase
        return r;
    endfunction

    typedef struct {
        imm_mode_e   mode;
        logic [15:0] imm;
        logic [31:0] data;
        logic        ovf;
    } vec_a_t;

    typedef struct {
        imm_mode_e   mode;
        logic [15:0] imm;
        logic [16:0] data;
        logic        ovf;
    } vec_b_t;

    vec_a_t    va[6];
    vec_b_t    vb[5];
    logic [24:0] q[$];
    logic [24:0] exp_c;
    logic [15:0] v;

    initial begin
        va[0] = '{IMM_SIGN,   16'h8001, 32'hFFFF8001, 1'b0};
        va[1] = '{IMM_ZERO,   16'h8001, 32'h00008001, 1'b0};
        va[2] = '{IMM_UPPER,  16'h1234, 32'h12340000, 1'b0};
        va[3] = '{IMM_BRANCH, 16'hFFFF, 32'hFFFFFFFC, 1'b0};
        va[4] = '{IMM_BRANCH, 16'h7FFF, 32'h0001FFFC, 1'b0};
        va[5] = '{IMM_BRANCH, 16'h8000, 32'hFFFE0000, 1'b0};

        vb[0] = '{IMM_SIGN,   16'h8001, 17'h18001, 1'b0};
        vb[1] = '{IMM_ZERO,   16'h8001, 17'h08001, 1'b0};
        vb[2] = '{IMM_BRANCH, 16'h7FFF, 17'h1FFFC, 1'b1};
        vb[3] = '{IMM_BRANCH, 16'hFFFF, 17'h1FFFC, 1'b0};
        vb[4] = '{IMM_BRANCH, 16'h4000, 17'h10000, 1'b1};

        reset = 1'b1;
        in_valid_a = 0; in_imm_a = '0; in_mode_a = '0; out_ready_a = 0;
        in_valid_b = 0; in_imm_b = '0; in_mode_b = '0; out_ready_b = 1;
        in_valid_c = 0; in_imm_c = '0; in_mode_c = '0; out_ready_c = 0;

        // Reset state
        #1;
        check("rst_in_ready", in_ready_a, 0);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_out_ovf", out_ovf_a, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready_a, 1);
        check("post_rst_out_valid", out_valid_a, 0);

        // Back-to-back stream, one cycle latency
        out_ready_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid_a = 1'b1;
            in_imm_a   = va[i].imm;
            in_mode_a  = va[i].mode;
            tick();
            check($sformatf("a_stream%0d_valid", i), out_valid_a, 1);
            check($sformatf("a_stream%0d_data", i), out_data_a, va[i].data);
            check($sformatf("a_stream%0d_ovf", i), out_ovf_a, va[i].ovf);
            check($sformatf("a_stream%0d_ready", i), in_ready_a, 1);
        end
        in_valid_a = 1'b0;
        tick();
        check("a_stream_drained", out_valid_a, 0);

        // Narrow output: BRANCH overflow cases
        for (int i = 0; i < 5; i++) begin
            in_valid_b = 1'b1;
            in_imm_b   = vb[i].imm;
            in_mode_b  = vb[i].mode;
            tick();
            check($sformatf("b_vec%0d_valid", i), out_valid_b, 1);
            check($sformatf("b_vec%0d_data", i), out_data_b, vb[i].data);
            check($sformatf("b_vec%0d_ovf", i), out_ovf_b, vb[i].ovf);
        end
        in_valid_b = 1'b0;
        tick();

        // Stall: A, B accepted, C held until the skid slot drains
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; in_mode_a = IMM_SIGN; in_imm_a = 16'h0001;     // A
        tick();
        check("stall_A_ready", in_ready_a, 1);
        check("stall_A_data", out_data_a, 32'h00000001);
        in_mode_a = IMM_ZERO; in_imm_a = 16'hFFFF;                         // B
        tick();
        check("stall_two_ready", in_ready_a, 0);
        check("stall_two_data", out_data_a, 32'h00000001);
        in_mode_a = IMM_UPPER; in_imm_a = 16'h00AB;                        // C
        tick();
        check("stall_hold_ready", in_ready_a, 0);
        check("stall_hold_valid", out_valid_a, 1);
        check("stall_hold_data", out_data_a, 32'h00000001);
        out_ready_a = 1'b1;
        tick();
        check("stall_B_data", out_data_a, 32'h0000FFFF);
        check("stall_recover_ready", in_ready_a, 1);
        tick();
        check("stall_C_valid", out_valid_a, 1);
        check("stall_C_data", out_data_a, 32'h00AB0000);
        in_valid_a = 1'b0;
        tick();
        check("stall_drained", out_valid_a, 0);

        // Simultaneous push/pop while in ONE
        for (int i = 0; i < 8; i++) begin
            v = 16'h0F00 + 16'(i);
            in_valid_a = 1'b1; in_mode_a = IMM_ZERO; in_imm_a = v;
            tick();
            check($sformatf("pp%0d_data", i), out_data_a, {16'h0000, v});
            check($sformatf("pp%0d_ready", i), in_ready_a, 1);
            check($sformatf("pp%0d_valid", i), out_valid_a, 1);
        end
        in_valid_a = 1'b0;
        tick();
        check("pp_drained", out_valid_a, 0);

        // Random handshake against the scoreboard (8 -> 24)
        for (int i = 0; i < 400; i++) begin
            check("c_valid", out_valid_c, q.size() != 0);
            check("c_ready", in_ready_c, q.size() < 2);
            in_valid_c  = ($urandom_range(0, 3) != 0);
            out_ready_c = ($urandom_range(0, 2) != 0);
            in_imm_c    = 8'($urandom_range(0, 255));
            in_mode_c   = 2'($urandom_range(0, 3));
            if (out_valid_c && out_ready_c && q.size() != 0) begin
                exp_c = q.pop_front();
                check("c_data", {out_ovf_c, out_data_c}, exp_c);
            end
            if (in_valid_c && in_ready_c) q.push_back(model8(in_imm_c, in_mode_c));
            tick();
        end
        in_valid_c  = 1'b0;
        out_ready_c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid_c && q.size() != 0) begin
                exp_c = q.pop_front();
                check("c_drain_data", {out_ovf_c, out_data_c}, exp_c);
            end
            tick();
        end
        check("c_drained_queue", q.size(), 0);
        check("c_drained_valid", out_valid_c, 0);

        // Asynchronous reset while in TWO
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; in_mode_a = IMM_SIGN; in_imm_a = 16'h00FF;
        tick();
        in_imm_a = 16'h0077;
        tick();
        check("mid_two_ready", in_ready_a, 0);
        in_valid_a = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid_a, 0);
        check("async_rst_data", out_data_a, 0);
        check("async_rst_ready", in_ready_a, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        out_ready_a = 1'b1;
        tick();
        check("rerst_ready", in_ready_a, 1);
        check("rerst_no_stale0", out_valid_a, 0);
        tick();
        check("rerst_no_stale1", out_valid_a, 0);
        in_valid_a = 1'b1; in_mode_a = IMM_ZERO; in_imm_a = 16'h0042;
        tick();
        check("rerst_new_data", out_data_a, 32'h00000042);
        in_valid_a = 1'b0;
        tick();
        check("rerst_no_stale2", out_valid_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
